// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and constants for the register write arbiter
package reg_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/flopenr.sv
// rtl/flopenr.sv - register with synchronous active-high reset and enable
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over a write presented in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin two-requester write arbiter over a register bank
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             last_grant,
    output logic [CNT_W-1:0] conflict_cnt
);

    req_id_t          prio;
    req_id_t          grant_id;
    logic             grant0;
    logic             grant1;
    logic             both_valid;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] bank [NREGS];

    // Grant selection: a lone requester always wins, contention goes to prio
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        both_valid = req0_valid & req1_valid;
        if (both_valid) begin
            grant0 = (prio == REQ0);
            grant1 = (prio == REQ1);
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
        req0_ready = grant0 & ~reset;
        req1_ready = grant1 & ~reset;
        grant_id   = grant1 ? REQ1 : REQ0;
        wr_en      = req0_ready | req1_ready;
        wr_addr    = grant1 ? req1_addr : req0_addr;
        wr_data    = grant1 ? req1_data : req0_data;
    end

    // Arbitration history and contention counter
    always_ff @(posedge clk) begin
        if (reset) begin
            prio         <= REQ0;
            last_grant   <= REQ0;
            conflict_cnt <= '0;
        end else begin
            if (wr_en) begin
                prio       <= ~grant_id;
                last_grant <= grant_id;
            end
            if (both_valid && conflict_cnt != CNT_MAX) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    // One enabled register per bank entry; only the addressed entry loads
    for (genvar i = 0; i < NREGS; i++) begin : g_bank
        flopenr #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (wr_en && (wr_addr == AW'(i))),
            .d     (wr_data),
            .q     (bank[i])
        );
    end

    assign rd_data = bank[rd_addr];

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter for a shared bank of sync-reset registers. Two independent requesters issue single-word writes through valid/ready handshakes. The block grants at most one write per clock, commits it into the register bank on the rising edge, and exposes a combinational read port. It sits between the two producer stages and the register bank; it is the only path by which bank contents change.

## Interface

- WIDTH, 8: data width of each register.
- NREGS, 4: number of registers in the bank; must be a power of two, at least 2.
- AW, $clog2(NREGS): address width; derived, not overridden.

Ports:

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  AW  requester 0 target register.
- req0_data  in  WIDTH  requester 0 write data.
- req0_ready  out  1  requester 0 write is accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0, for requester 1.
- rd_addr  in  AW  read address.
- rd_data  out  WIDTH  contents of register rd_addr; combinational.
- last_grant  out  1  id of the most recently granted requester.
- conflict_cnt  out  8  saturating count of cycles in which both requesters were valid.

## Operation

- Priority pointer `prio` (1 bit) holds the favoured requester. Reset value: 0.
- Grant logic is combinational:
  - Only one requester valid: that requester is granted.
  - Both valid: requester `prio` is granted.
  - Neither valid: no grant.
- readyN = grantN AND NOT reset. Both ready outputs are never high together. A requester that is not granted keeps valid and holds its addr/data stable until ready.
- Accepted write: valid AND ready at the rising edge. Register[addr] <= data at that edge. No other register changes.
- After any grant, prio <= complement of the granted id, and last_grant <= granted id. With no grant, both are held.
- Both valid in the same cycle: conflict_cnt increments and saturates at 255 (no wrap).
- Same address from both requesters in one cycle: the winner writes first and the loser writes on the next cycle. The final value is the loser's data.
- Reset: all registers, prio, last_grant and conflict_cnt go to 0. Reset takes precedence over any write presented in the same cycle; that write is not accepted, and ready is 0 during reset.

## Timing

- Grant-to-commit latency: 0 cycles. Ready is asserted in the same cycle as valid, and the write lands on that cycle's edge.
- Write-to-read visibility: 1 cycle. rd_data reflects the new value immediately after the committing edge.
- Throughput: 1 write/cycle aggregate. Under continuous contention, each requester receives exactly every other cycle (strict alternation, no starvation).
- Worst-case wait for a valid requester: 1 cycle.
- Reset deasserted on edge k: the first accepted write is possible on edge k+1.

## Structure

- Package reg_arb_pkg holds:
  - typedef req_id_t (1-bit requester id) and constants REQ0, REQ1;
  - CNT_W = 8 and CNT_MAX = 255 for conflict_cnt.
- Sub-module flopenr: WIDTH-wide register with synchronous active-high reset and enable. The bank uses one instance per register; enable = accepted write AND address match.
- The top level contains the grant logic, the prio/last_grant/conflict_cnt registers and the read mux.

## Test plan

- Reset, then read all addresses -> rd_data = 0 at every address; req0_ready = req1_ready = 0 while reset = 1; conflict_cnt = 0.
- req0 alone writes 8'hA5 to addr 2 -> req0_ready = 1 the same cycle; rd_data(2) = 8'hA5 after the edge; last_grant = 0; prio = 1.
- Both valid for 6 cycles (req0 to addr 1, req1 to addr 3, with changing data) -> grants alternate 0,1,0,1,0,1; conflict_cnt = 6; never both ready.
- Both target addr 0 simultaneously (req0 8'h11, req1 8'h22) with prio = 0 -> cycle 1 writes 8'h11, cycle 2 writes 8'h22; final rd_data(0) = 8'h22.
- Hold contention for 300 cycles -> conflict_cnt saturates at 255 and stays there.
- Assert reset in the same cycle as req1_valid writing 8'hFF to addr 3 -> req1_ready = 0; rd_data(3) = 0; prio = 0 afterwards.
